// File: rtl/pattern_tx_pkg.sv
// Shared types and elaboration-time helpers for the serial pattern transmitter.
package pattern_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  // Ceiling log2 for sizing counters at elaboration time.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Never let a counter width collapse to zero bits.
  function automatic int unsigned max1(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/pattern_tx_if.sv
// Load-side handshake bundle: a word plus its repeat count over valid/ready.
interface pattern_tx_if #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned REPW  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data;
  logic [REPW-1:0]  reps;

  modport master (output in_valid, output data, output reps, input in_ready);
  modport slave  (input in_valid, input data, input reps, output in_ready);
endinterface

// File: rtl/piso_shift.sv
// Parallel-in / serial-out shift register, MSB first.
// next_msb_c exposes the bit that will sit at the MSB after this edge,
// so the owner can register the serial output without a bubble.
module piso_shift #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] pdata,
  output logic             next_msb_c
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Load has priority over shift; otherwise hold.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = pdata;
    end else if (shift) begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  assign next_msb_c = sr_d[WIDTH-1];

  // Shift register storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends an accepted word MSB-first, repeated
// max(reps,1) times, with GAP idle cycles between repeats.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned GAP   = 0,
  parameter int unsigned REPW  = 4
) (
  input  logic         clk,
  input  logic         reset,
  pattern_tx_if.slave  in_if,
  output logic         out,
  output logic         out_valid,
  output logic         busy,
  output logic         done
);

  localparam int unsigned BCW = max1(clog2(WIDTH));
  localparam int unsigned GW  = max1(clog2(GAP + 1));
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'((GAP > 0) ? GAP - 1 : GAP);
  localparam bit             HAS_GAP  = (GAP != 0);

  state_e            state_q, state_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [REPW-1:0]   rep_left_q, rep_left_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic              out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;

  logic              sr_load;
  logic              sr_shift;
  logic [WIDTH-1:0]  sr_pdata;
  logic              next_msb_c;

  logic              in_valid_c;
  logic [WIDTH-1:0]  data_c;
  logic [REPW-1:0]   reps_c;

  assign in_valid_c     = in_if.in_valid;
  assign data_c         = in_if.data;
  assign reps_c         = in_if.reps;
  assign in_if.in_ready = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign out            = out_q;
  assign out_valid      = out_valid_q;
  assign done           = done_q;

  piso_shift #(.WIDTH(WIDTH)) u_piso (
    .clk        (clk),
    .reset      (reset),
    .load       (sr_load),
    .shift      (sr_shift),
    .pdata      (sr_pdata),
    .next_msb_c (next_msb_c)
  );

  // Next-state, counters and shift-register control.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rep_left_d = rep_left_q;
    word_d     = word_q;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    sr_pdata   = word_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid_c) begin
          sr_load    = 1'b1;
          sr_pdata   = data_c;
          word_d     = data_c;
          rep_left_d = (reps_c == '0) ? REPW'(1) : reps_c;
          bit_cnt_d  = '0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d  = '0;
          rep_left_d = rep_left_q - REPW'(1);
          if (rep_left_q > REPW'(1)) begin
            // Reload now; during a gap the register simply holds the word.
            sr_load = 1'b1;
            if (HAS_GAP) begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
            end
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          sr_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Serial line is only driven while the next cycle is a shift cycle.
  always_comb begin
    out_valid_d = (state_d == S_SHIFT);
    out_d       = (state_d == S_SHIFT) & next_msb_c;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      rep_left_q  <= '0;
      word_q      <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rep_left_q  <= rep_left_d;
      word_q      <= word_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

endmodule
